key_search_ctrl: RTL and testbench

KEY_SEARCH_CTRL -- requirements
Module: key_search_ctrl

---
 rtl/key_search_ctrl_if.sv | 35 +++
 rtl/key_search_ctrl.sv | 145 ++++++++++++++
 tb/tb_key_search_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_search_ctrl_if.sv
// Handshake and data bundle between the key search controller, the three RC4 loop FSMs,
// the S-RAM port mux and the D-RAM read port.
interface key_search_ctrl_if #(
  parameter int unsigned KEY_W = 24
);
  logic             start;
  logic [KEY_W-1:0] key_lo;
  logic [KEY_W-1:0] key_hi;
  logic             init_start;
  logic             shuffle_start;
  logic             decrypt_start;
  logic             init_finish;
  logic             shuffle_finish;
  logic             decrypt_finish;
  logic             sub_reset;
  logic [1:0]       s_sel;
  logic [KEY_W-1:0] secret_key;
  logic [7:0]       d_address;
  logic [7:0]       d_q;
  logic             busy;
  logic             done;
  logic             key_found;

  modport master (
    input  start, key_lo, key_hi, init_finish, shuffle_finish, decrypt_finish, d_q,
    output init_start, shuffle_start, decrypt_start, sub_reset, s_sel, secret_key,
    output d_address, busy, done, key_found
  );

  modport slave (
    output start, key_lo, key_hi, init_finish, shuffle_finish, decrypt_finish, d_q,
    input  init_start, shuffle_start, decrypt_start, sub_reset, s_sel, secret_key,
    input  d_address, busy, done, key_found
  );
endinterface

// File: rtl/key_search_ctrl.sv
// Brute-force key search: sequences init/shuffle/decrypt loops per key, then scans the
// decrypted message for printable lowercase/space bytes and stops on the first good key.
module key_search_ctrl #(
  parameter int unsigned MSG_LEN = 32,
  parameter int unsigned KEY_W   = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  key_search_ctrl_if.master    bus
);

  localparam int unsigned     IDX_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, RUN_INIT, RUN_SHUF, RUN_DEC, CHK_REQ, CHK_W1, CHK_W2, CHK_RD,
    NEXT_KEY, SUB_RST, DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [KEY_W-1:0]  r_key, w_key_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [7:0]        r_addr, w_addr_nxt;
  logic              r_found, w_found_nxt;
  logic              r_init_start, r_shuf_start, r_dec_start, r_sub_reset;
  logic              r_busy, r_done;
  logic [1:0]        r_s_sel, w_s_sel_nxt;
  logic              w_byte_ok;

  assign w_byte_ok = ((bus.d_q >= 8'h61) && (bus.d_q <= 8'h7A)) || (bus.d_q == 8'h20);

  // Next-state and datapath updates
  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_idx_nxt   = r_idx;
    w_addr_nxt  = r_addr;
    w_found_nxt = r_found;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_key_nxt   = bus.key_lo;
          w_idx_nxt   = '0;
          w_state_nxt = RUN_INIT;
        end
      end
      RUN_INIT: if (bus.init_finish)    w_state_nxt = RUN_SHUF;
      RUN_SHUF: if (bus.shuffle_finish) w_state_nxt = RUN_DEC;
      RUN_DEC: begin
        if (bus.decrypt_finish) begin
          w_idx_nxt   = '0;
          w_state_nxt = CHK_REQ;
        end
      end
      CHK_REQ: begin
        w_addr_nxt  = 8'(r_idx);
        w_state_nxt = CHK_W1;
      end
      CHK_W1: w_state_nxt = CHK_W2;
      CHK_W2: w_state_nxt = CHK_RD;
      CHK_RD: begin
        if (!w_byte_ok) begin
          w_state_nxt = NEXT_KEY;
        end else if (r_idx == IDX_LAST) begin
          w_found_nxt = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_idx_nxt   = IDX_W'(r_idx + 1'b1);
          w_state_nxt = CHK_REQ;
        end
      end
      // >= also ends a reversed range after its single key and stops before any wrap
      NEXT_KEY: begin
        if (r_key >= bus.key_hi) begin
          w_found_nxt = 1'b0;
          w_state_nxt = DONE;
        end else begin
          w_key_nxt   = KEY_W'(r_key + 1'b1);
          w_state_nxt = SUB_RST;
        end
      end
      SUB_RST: w_state_nxt = RUN_INIT;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (w_state_nxt)
      RUN_INIT: w_s_sel_nxt = 2'd0;
      RUN_SHUF: w_s_sel_nxt = 2'd1;
      RUN_DEC:  w_s_sel_nxt = 2'd2;
      default:  w_s_sel_nxt = 2'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs are registered from the next state so they align with the state they decode
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key        <= '0;
      r_idx        <= '0;
      r_addr       <= '0;
      r_found      <= 1'b0;
      r_init_start <= 1'b0;
      r_shuf_start <= 1'b0;
      r_dec_start  <= 1'b0;
      r_sub_reset  <= 1'b1;
      r_s_sel      <= 2'd3;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_key        <= w_key_nxt;
      r_idx        <= w_idx_nxt;
      r_addr       <= w_addr_nxt;
      r_found      <= w_found_nxt;
      r_init_start <= (w_state_nxt == RUN_INIT);
      r_shuf_start <= (w_state_nxt == RUN_SHUF);
      r_dec_start  <= (w_state_nxt == RUN_DEC);
      r_sub_reset  <= (w_state_nxt == SUB_RST);
      r_s_sel      <= w_s_sel_nxt;
      r_busy       <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
      r_done       <= (w_state_nxt == DONE);
    end
  end

  assign bus.init_start    = r_init_start;
  assign bus.shuffle_start = r_shuf_start;
  assign bus.decrypt_start = r_dec_start;
  assign bus.sub_reset     = r_sub_reset;
  assign bus.s_sel         = r_s_sel;
  assign bus.secret_key    = r_key;
  assign bus.d_address     = r_addr;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.key_found     = r_found;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench for key_search_ctrl with 10-cycle loop FSM models and a registered D-RAM.
module tb_key_search_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic force_shuf;
  logic [7:0] mem [32];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  key_search_ctrl_if #(.KEY_W(24)) bus ();

  key_search_ctrl #(.MSG_LEN(32), .KEY_W(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Loop FSM models: FINISH rises after 10 cycles of START, sticky until sub_reset
  logic [3:0] c_init, c_shuf, c_dec;
  logic       f_init, f_shuf, f_dec;
  always @(posedge clk) begin
    if (bus.sub_reset) begin
      c_init <= '0; c_shuf <= '0; c_dec <= '0;
      f_init <= 1'b0; f_shuf <= 1'b0; f_dec <= 1'b0;
    end else begin
      if (bus.init_start && !f_init) begin
        c_init <= c_init + 4'd1;
        if (c_init == 4'd9) f_init <= 1'b1;
      end
      if (bus.shuffle_start && !f_shuf) begin
        c_shuf <= c_shuf + 4'd1;
        if (c_shuf == 4'd9) f_shuf <= 1'b1;
      end
      if (bus.decrypt_start && !f_dec) begin
        c_dec <= c_dec + 4'd1;
        if (c_dec == 4'd9) f_dec <= 1'b1;
      end
    end
  end
  assign bus.init_finish    = f_init;
  assign bus.shuffle_finish = f_shuf | force_shuf;
  assign bus.decrypt_finish = f_dec;

  always @(posedge clk) bus.d_q <= mem[bus.d_address[4:0]];

  // Running monitors: pass starts, sub_reset pulses, start overlap, S-RAM ownership
  int   n_pass = 0, n_subrst = 0, n_multi = 0, n_ssel_bad = 0;
  logic prev_init = 1'b0;
  logic [1:0] exp_sel;
  always begin
    @(posedge clk); #1;
    if (reset === 1'b0) begin
      if (bus.init_start === 1'b1 && prev_init === 1'b0) n_pass++;
      if (bus.sub_reset === 1'b1) n_subrst++;
      if ((int'(bus.init_start) + int'(bus.shuffle_start) + int'(bus.decrypt_start)) > 1) n_multi++;
      exp_sel = bus.init_start ? 2'd0 : bus.shuffle_start ? 2'd1 : bus.decrypt_start ? 2'd2 : 2'd3;
      if (bus.s_sel !== exp_sel) n_ssel_bad++;
    end
    prev_init = bus.init_start;
  end

  localparam logic [4:0] BB_POS [6] = '{5'd31, 5'd31, 5'd0,  5'd0,  5'd5,  5'd12};
  localparam logic [7:0] BB_VAL [6] = '{8'h7B, 8'h7A, 8'h60, 8'h20, 8'h41, 8'h61};
  localparam logic       BB_OK  [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 32; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic run_search(input logic [23:0] lo, input logic [23:0] hi);
    int k;
    bus.key_lo = lo;
    bus.key_hi = hi;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    k = 0;
    while (bus.done !== 1'b1 && k < 3000) begin tick(); k++; end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL search_timeout lo=%h hi=%h done=%b exp=1", lo, hi, bus.done); end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0;
    tick(); tick();
    n_checks++; if (bus.sub_reset !== 1'b1) begin n_fail++; $display("FAIL reset_sub_reset got=%b exp=1", bus.sub_reset); end
    n_checks++; if ({bus.busy, bus.done, bus.key_found} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {bus.busy, bus.done, bus.key_found}); end
    n_checks++; if (bus.secret_key !== 24'h0) begin n_fail++; $display("FAIL reset_key got=%h exp=000000", bus.secret_key); end
    n_checks++; if (bus.d_address !== 8'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=00", bus.d_address); end
    n_checks++; if (bus.s_sel !== 2'd3) begin n_fail++; $display("FAIL reset_s_sel got=%0d exp=3", bus.s_sel); end
    n_checks++; if ({bus.init_start, bus.shuffle_start, bus.decrypt_start} !== 3'b000) begin n_fail++; $display("FAIL reset_starts got=%b exp=000", {bus.init_start, bus.shuffle_start, bus.decrypt_start}); end
    bus.start = 1'b1;
    tick();
    n_checks++; if ({bus.busy, bus.init_start} !== 2'b00) begin n_fail++; $display("FAIL reset_over_start got=%b exp=00", {bus.busy, bus.init_start}); end
    bus.start = 1'b0; reset = 1'b0;
    tick(); tick();
    n_checks++; if ({bus.sub_reset, bus.busy, bus.s_sel} !== 4'b0011) begin n_fail++; $display("FAIL idle_hold got=%b exp=0011", {bus.sub_reset, bus.busy, bus.s_sel}); end
  endtask

  task automatic test_single_key_found();
    int p0, s0;
    do_reset(); fill_mem(8'h61);
    p0 = n_pass; s0 = n_subrst;
    run_search(24'h000249, 24'h000249);
    n_checks++; if (bus.key_found !== 1'b1) begin n_fail++; $display("FAIL single_found got=%b exp=1", bus.key_found); end
    n_checks++; if (bus.secret_key !== 24'h000249) begin n_fail++; $display("FAIL single_key got=%h exp=000249", bus.secret_key); end
    n_checks++; if (bus.d_address !== 8'd31) begin n_fail++; $display("FAIL single_last_addr got=%0d exp=31", bus.d_address); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got=%b exp=0", bus.busy); end
    n_checks++; if ((n_pass - p0) !== 1 || (n_subrst - s0) !== 0) begin n_fail++; $display("FAIL single_passes got=%0d/%0d exp=1/0", n_pass - p0, n_subrst - s0); end
    bus.key_lo = 24'h5; bus.start = 1'b1;
    repeat (5) tick();
    bus.start = 1'b0;
    n_checks++; if ({bus.done, bus.key_found, bus.init_start} !== 3'b110 || bus.secret_key !== 24'h000249) begin n_fail++; $display("FAIL done_hold got=%b key=%h exp=110 key=000249", {bus.done, bus.key_found, bus.init_start}, bus.secret_key); end
  endtask

  task automatic test_range_not_found();
    int p0, s0;
    do_reset(); fill_mem(8'h61); mem[0] = 8'h00;
    p0 = n_pass; s0 = n_subrst;
    run_search(24'h0, 24'h3);
    n_checks++; if (bus.key_found !== 1'b0) begin n_fail++; $display("FAIL range_found got=%b exp=0", bus.key_found); end
    n_checks++; if (bus.secret_key !== 24'h3) begin n_fail++; $display("FAIL range_key got=%h exp=000003", bus.secret_key); end
    n_checks++; if ((n_pass - p0) !== 4) begin n_fail++; $display("FAIL range_passes got=%0d exp=4", n_pass - p0); end
    n_checks++; if ((n_subrst - s0) !== 3) begin n_fail++; $display("FAIL range_sub_resets got=%0d exp=3", n_subrst - s0); end
  endtask

  task automatic test_byte_bounds();
    for (int i = 0; i < 6; i++) begin
      do_reset(); fill_mem(8'h20); mem[BB_POS[i]] = BB_VAL[i];
      run_search(24'd100 + 24'(i), 24'd100 + 24'(i));
      n_checks++; if (bus.key_found !== BB_OK[i]) begin n_fail++; $display("FAIL byte_%0d_found val=%h got=%b exp=%b", i, BB_VAL[i], bus.key_found, BB_OK[i]); end
      n_checks++; if (bus.d_address !== (BB_OK[i] ? 8'd31 : 8'(BB_POS[i]))) begin n_fail++; $display("FAIL byte_%0d_stop_addr got=%0d exp=%0d", i, bus.d_address, BB_OK[i] ? 31 : int'(BB_POS[i])); end
    end
  endtask

  task automatic test_finish_ignored();
    int k;
    do_reset(); fill_mem(8'h61);
    force_shuf = 1'b1;
    bus.key_lo = 24'h10; bus.key_hi = 24'h10; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    n_checks++; if ({bus.s_sel, bus.init_start, bus.shuffle_start} !== 4'b0010) begin n_fail++; $display("FAIL early_shuf_finish got=%b exp=0010", {bus.s_sel, bus.init_start, bus.shuffle_start}); end
    k = 0;
    while (bus.init_start === 1'b1 && k < 50) begin tick(); k++; end
    n_checks++; if ({bus.s_sel, bus.shuffle_start} !== 3'b011) begin n_fail++; $display("FAIL enter_shuf got=%b exp=011", {bus.s_sel, bus.shuffle_start}); end
    tick();
    n_checks++; if ({bus.s_sel, bus.decrypt_start} !== 3'b101) begin n_fail++; $display("FAIL enter_dec got=%b exp=101", {bus.s_sel, bus.decrypt_start}); end
    force_shuf = 1'b0;
    k = 0;
    while (bus.done !== 1'b1 && k < 1000) begin tick(); k++; end
    n_checks++; if ({bus.done, bus.key_found} !== 2'b11) begin n_fail++; $display("FAIL forced_run_result got=%b exp=11", {bus.done, bus.key_found}); end
  endtask

  task automatic test_reset_mid_check();
    int p0, k;
    do_reset(); fill_mem(8'h61); mem[0] = 8'h00;
    p0 = n_pass;
    bus.key_lo = 24'h2; bus.key_hi = 24'h6; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0;
    while ((n_pass - p0) < 2 && k < 1000) begin tick(); k++; end
    while (bus.decrypt_start !== 1'b1 && k < 1000) begin tick(); k++; end
    while (bus.decrypt_start === 1'b1 && k < 1000) begin tick(); k++; end
    tick(); tick();
    n_checks++; if (bus.secret_key !== 24'h3) begin n_fail++; $display("FAIL pass2_key got=%h exp=000003", bus.secret_key); end
    reset = 1'b1;
    tick();
    n_checks++; if ({bus.busy, bus.done, bus.key_found, bus.sub_reset} !== 4'b0001) begin n_fail++; $display("FAIL midreset_flags got=%b exp=0001", {bus.busy, bus.done, bus.key_found, bus.sub_reset}); end
    n_checks++; if (bus.secret_key !== 24'h0 || bus.d_address !== 8'h0 || bus.s_sel !== 2'd3) begin n_fail++; $display("FAIL midreset_regs key=%h addr=%h sel=%0d exp 000000/00/3", bus.secret_key, bus.d_address, bus.s_sel); end
    n_checks++; if ({bus.init_start, bus.shuffle_start, bus.decrypt_start} !== 3'b000) begin n_fail++; $display("FAIL midreset_starts got=%b exp=000", {bus.init_start, bus.shuffle_start, bus.decrypt_start}); end
    reset = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++; if (bus.secret_key !== 24'h2 || {bus.busy, bus.init_start} !== 2'b11) begin n_fail++; $display("FAIL restart key=%h busy_init=%b exp key=000002 11", bus.secret_key, {bus.busy, bus.init_start}); end
  endtask

  task automatic test_all_ones();
    int p0;
    do_reset(); fill_mem(8'h61); mem[0] = 8'hFF;
    p0 = n_pass;
    run_search(24'hFFFFFF, 24'hFFFFFF);
    n_checks++; if (bus.key_found !== 1'b0 || bus.secret_key !== 24'hFFFFFF) begin n_fail++; $display("FAIL all_ones found=%b key=%h exp 0 ffffff", bus.key_found, bus.secret_key); end
    n_checks++; if ((n_pass - p0) !== 1) begin n_fail++; $display("FAIL all_ones_passes got=%0d exp=1", n_pass - p0); end
  endtask

  task automatic test_lo_gt_hi();
    int p0;
    do_reset(); fill_mem(8'h7A);
    p0 = n_pass;
    run_search(24'd10, 24'd4);
    n_checks++; if (bus.key_found !== 1'b1 || bus.secret_key !== 24'd10 || (n_pass - p0) !== 1) begin n_fail++; $display("FAIL rev_good found=%b key=%h passes=%0d exp 1 00000a 1", bus.key_found, bus.secret_key, n_pass - p0); end
    do_reset(); mem[3] = 8'h5B;
    p0 = n_pass;
    run_search(24'd10, 24'd4);
    n_checks++; if (bus.key_found !== 1'b0 || bus.secret_key !== 24'd10 || (n_pass - p0) !== 1) begin n_fail++; $display("FAIL rev_bad found=%b key=%h passes=%0d exp 0 00000a 1", bus.key_found, bus.secret_key, n_pass - p0); end
  endtask

  initial begin
    reset = 1'b1; force_shuf = 1'b0;
    bus.start = 1'b0; bus.key_lo = '0; bus.key_hi = '0;
    fill_mem(8'h61);
    test_reset();
    test_single_key_found();
    test_range_not_found();
    test_byte_bounds();
    test_finish_ignored();
    test_reset_mid_check();
    test_all_ones();
    test_lo_gt_hi();
    n_checks++; if (n_multi !== 0) begin n_fail++; $display("FAIL overlapping_starts got=%0d exp=0", n_multi); end
    n_checks++; if (n_ssel_bad !== 0) begin n_fail++; $display("FAIL s_sel_ownership got=%0d bad cycles exp=0", n_ssel_bad); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
